// File: rtl/pkt_qos_sched_pkg.sv
// Shared types and helpers for the packet QoS scheduler.
package pkt_qos_sched_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned ID_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Binary index of a one-hot vector; returns 0 for an all-zero vector.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pkt_qos_sched_rr_pick8.sv
// Rotating-priority picker: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import pkt_qos_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [ID_W-1:0]   idx,
  output logic              any
);

  // Scan from ptr upward; the 3-bit add wraps naturally modulo 8.
  always_comb begin
    logic [ID_W-1:0] cand;
    onehot = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = ptr + ID_W'(i);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
      end
    end
    idx = onehot_to_idx(onehot);
  end

endmodule

// File: rtl/pkt_qos_sched.sv
// Packet-granular two-class scheduler with round-robin within each class,
// a high-priority burst limit and a per-packet beat watchdog.
module pkt_qos_sched
  import pkt_qos_sched_pkg::*;
#(
  parameter int unsigned HP_BURST_MAX = 4,
  parameter int unsigned MAX_PKT_LEN  = 256,
  parameter int unsigned CNT_W        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sched_en,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_qos,
  input  logic [NUM_CH-1:0] ch_eop,
  input  logic              out_rdy,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              grant_vld,
  output logic              grant_qos,
  output logic              pkt_start,
  output logic              pkt_done,
  output logic              timeout_err
);

  localparam int unsigned STREAK_W = $clog2(HP_BURST_MAX + 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     hp_ptr, lp_ptr;
  logic [STREAK_W-1:0] hp_streak;
  logic [CNT_W-1:0]    beat_cnt;

  logic [NUM_CH-1:0]   hp_set, lp_set, hp_oh, lp_oh;
  logic [ID_W-1:0]     hp_idx, lp_idx;
  logic                hp_any, lp_any;
  logic                beat, eop_beat, wdog, release_pkt;
  logic                decide, streak_full, pick_hp, pick_lp;

  assign hp_set = ch_req & ch_qos;
  assign lp_set = ch_req & ~ch_qos;

  rr_pick8 u_hp_pick (.req(hp_set), .ptr(hp_ptr), .onehot(hp_oh), .idx(hp_idx), .any(hp_any));
  rr_pick8 u_lp_pick (.req(lp_set), .ptr(lp_ptr), .onehot(lp_oh), .idx(lp_idx), .any(lp_any));

  assign beat        = grant_vld & out_rdy;
  assign eop_beat    = beat & ch_eop[grant_id];
  assign wdog        = beat & ~ch_eop[grant_id] & (beat_cnt == CNT_W'(MAX_PKT_LEN - 1));
  assign release_pkt = eop_beat | wdog;

  // Low priority wins when the HP burst budget is spent or no HP is pending.
  assign streak_full = (hp_streak == STREAK_W'(HP_BURST_MAX));
  assign pick_lp     = lp_any & (streak_full | ~hp_any);
  assign pick_hp     = hp_any & ~pick_lp;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Decision point and next state; a release with a candidate re-enters BUSY with no gap.
  always_comb begin
    decide    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        decide = sched_en & (|ch_req);
        if (decide) state_nxt = BUSY;
      end
      BUSY: begin
        decide = release_pkt & sched_en;
        if (release_pkt) state_nxt = (decide && (pick_hp || pick_lp)) ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-beat status strobes, suppressed while reset is asserted.
  always_comb begin
    pkt_done    = ~rst & eop_beat;
    timeout_err = ~rst & wdog;
  end

  // Grant registers, class pointers, burst streak and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      grant_id  <= '0;
      grant_vld <= 1'b0;
      grant_qos <= 1'b0;
      pkt_start <= 1'b0;
      hp_ptr    <= '0;
      lp_ptr    <= '0;
      hp_streak <= '0;
      beat_cnt  <= '0;
    end else begin
      pkt_start <= 1'b0;
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (decide) begin
        beat_cnt <= '0;
        if (pick_hp) begin
          grant     <= hp_oh;
          grant_id  <= hp_idx;
          grant_vld <= 1'b1;
          grant_qos <= 1'b1;
          pkt_start <= 1'b1;
          hp_ptr    <= hp_idx + 1'b1;
          if (!lp_any)          hp_streak <= '0;
          else if (!streak_full) hp_streak <= hp_streak + 1'b1;
        end else if (pick_lp) begin
          grant     <= lp_oh;
          grant_id  <= lp_idx;
          grant_vld <= 1'b1;
          grant_qos <= 1'b0;
          pkt_start <= 1'b1;
          lp_ptr    <= lp_idx + 1'b1;
          hp_streak <= '0;
        end else begin
          grant     <= '0;
          grant_id  <= '0;
          grant_vld <= 1'b0;
          grant_qos <= 1'b0;
          hp_streak <= '0;
        end
      end else if (release_pkt) begin
        grant     <= '0;
        grant_id  <= '0;
        grant_vld <= 1'b0;
        grant_qos <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pkt_qos_sched.md
Name: pkt_qos_sched

Overview:
Packet-granular scheduler that decides which of the 8 source channels owns the shared channel-output mux. It uses two-level arbitration: strict priority for QoS channels, and round-robin within each class. An anti-starvation burst limit guarantees low-priority channels periodic service. The grant is held from the decision until the granted channel's end-of-packet, and a watchdog releases the grant if a packet overruns.

Parameters:
NUM_CH, 8, number of source channels (fixed at 8 in this revision)
ID_W, 3, channel id width
HP_BURST_MAX, 4, max consecutive high-priority packets granted while low-priority requests wait
MAX_PKT_LEN, 256, beat limit per packet before watchdog release
CNT_W, 9, beat counter width; must satisfy 2^CNT_W > MAX_PKT_LEN

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sched_en  in  1  permits new arbitration decisions
ch_req  in  8  per-channel packet-pending request
ch_qos  in  8  per-channel class; 1 means high priority
ch_eop  in  8  per-channel end-of-packet, aligned with that channel's data
out_rdy  in  1  downstream accepts a beat this cycle
grant  out  8  one-hot owner of the output mux, registered
grant_id  out  3  binary index of grant, registered
grant_vld  out  1  a packet is in progress, registered
grant_qos  out  1  class of the granted packet, latched at decision
pkt_start  out  1  1-cycle pulse on the first cycle of grant_vld
pkt_done  out  1  combinational; high on the eop beat
timeout_err  out  1  1-cycle pulse on watchdog release

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset behaviour: all outputs are 0; state=IDLE; hp_ptr=lp_ptr=0; hp_streak=0; beat_cnt=0. Reset asserted mid-packet drops the grant at the next edge, and no pkt_done is produced.
- FSM has two states, IDLE and BUSY.
- Decision point: IDLE with sched_en and (ch_req != 0), or BUSY on an eop beat or a timeout while sched_en=1.
- Decision latency: a request sampled at edge N produces grant at N+1, with pkt_start=1 in that cycle.
- Class sets: HP = ch_req & ch_qos; LP = ch_req & ~ch_qos.
- Selection at each decision:
  - If hp_streak == HP_BURST_MAX and LP != 0: pick from LP.
  - Else if HP != 0: pick from HP.
  - Else: pick from LP.
  - If no candidate: go to IDLE, grant=0.
- Round-robin: search starts at the class pointer and wraps 7->0. After granting channel k, that class pointer becomes (k+1) mod 8. The other class pointer is unchanged.
- hp_streak:
  - Increments (saturating at HP_BURST_MAX) when HP is picked while LP != 0.
  - Clears when LP is picked, or when LP == 0 at a decision.
- Beat definition: beat = grant_vld & out_rdy. beat_cnt resets to 0 at a decision and increments on each beat.
- eop beat: beat & ch_eop[grant_id]. pkt_done=1 in that same cycle. ch_eop is ignored without out_rdy, and eop from non-granted channels is ignored.
- Back-to-back packets: at an eop beat the next decision occurs in the same cycle, so the new grant is active at the next edge with no gap. The same channel can be re-granted if it is the only requester.
- Watchdog: when a beat occurs with beat_cnt == MAX_PKT_LEN-1 and no eop, release the grant, pulse timeout_err, and leave pkt_done=0. The next decision follows the same rules.
- During BUSY, ch_req changes and ch_qos changes are ignored; grant_qos stays at its latched value.
- sched_en=0 blocks only new decisions: the current packet completes, then the block goes to IDLE.
- Invariants: grant is always one-hot or zero; grant_vld == (grant != 0).

Decomposition:
- Shared package holds: NUM_CH, ID_W, the state enum {IDLE, BUSY}, and a onehot-to-index function.
- One natural sub-module, rr_pick8: combinational rotating-priority picker with inputs req[7:0] and ptr[2:0], and outputs onehot[7:0], idx[2:0] and any. It is instantiated twice, once for HP and once for LP.
- The FSM, counters and pointers live in the top level.

Test Plan:
1. After reset, ch_req=0x05, ch_qos=0, out_rdy=1, ch_eop[0] on the 3rd beat -> grant=0x01 and pkt_start one cycle after the request; pkt_done on beat 3; next cycle grant=0x04 with no gap; lp_ptr=3.
2. ch_req=0x81, ch_qos=0x80 -> ch7 is granted first despite ptr=0; ch0 is granted after ch7's eop; grant_qos=1 then 0.
3. HP_BURST_MAX=4; ch1 and ch2 are HP and always requesting; ch5 is LP and requesting; 1-beat packets -> grant order 1,2,1,2,5,1,2,1,2,5.
4. MAX_PKT_LEN=16 with no eop -> timeout_err pulses on the 16th beat; pkt_done stays 0; grant=0 the next cycle when there are no other requests.
5. out_rdy=0 while ch_eop[grant_id]=1 -> no release and no pkt_done; with out_rdy=1 one cycle later, pkt_done=1 and the grant is released at the following edge.
6. rst=1 mid-packet -> all outputs 0 at the next edge. Separately, sched_en dropped mid-packet -> the packet completes and the block goes to IDLE with grant=0 despite ch_req=0xFF.
